spi_slave: RTL

Parametrised full-duplex SPI slave. It oversamples SCLK, SS and MOSI on the system clock and supports all four CPOL/CPHA modes and any word width. It receives MSB-first words on MOSI and transmits MSB-first words on MISO from a one-deep, handshaked transmit buffer. It sits between an external SPI master and the fabric logic that consumes received bytes and supplies replies.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_slave.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave.
// FSM state type, edge-pattern encodings and the CPOL/CPHA mode encoding.
package spi_pkg;

  // Slave is either waiting for SS to fall or inside a frame
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // {previous, current} synchronised sample patterns
  localparam logic [1:0] EDGE_RISING  = 2'b01;
  localparam logic [1:0] EDGE_FALLING = 2'b10;

  // SPI mode encoded as {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic logic [1:0] spi_mode(input int cpol, input int cpha);
    return {(cpol != 0), (cpha != 0)};
  endfunction

  // Data is sampled on the SCLK rising edge in modes 0 and 3, falling in 1 and 2
  function automatic logic sample_on_rising(input logic [1:0] mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE3);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for an asynchronous input with
// registered one-cycle rising/falling edge pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Synchronise the input and flag transitions between the last two samples
  always_ff @(posedge CLK) begin
    if (RST) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din_i};
      prev_q  <= chain_q[STAGES-1];
      rise_q  <= ({prev_q, chain_q[STAGES-1]} == EDGE_RISING);
      fall_q  <= ({prev_q, chain_q[STAGES-1]} == EDGE_FALLING);
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled full-duplex SPI slave, any CPOL/CPHA, MSB first,
// with a one-deep handshaked transmit buffer.
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN adds the frame_error pulse
// reported when SS rises in the middle of a word.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  slave_select,
  input  logic                  master_clock,
  input  logic                  mosi,
  output logic                  miso,
  output logic [WORD_WIDTH-1:0] rx_word,
  output logic                  rx_valid,
  input  logic [WORD_WIDTH-1:0] tx_word,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                  frame_error
`endif
);

  localparam int         CNT_W       = $clog2(WORD_WIDTH);
  localparam logic [1:0] MODE        = spi_mode(CPOL, CPHA);
  localparam logic       SAMPLE_RISE = sample_on_rising(MODE);
  localparam logic       HOLD_FIRST  = MODE[0];
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic sample_edge, shift_edge;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_WIDTH-1:0] rx_word_q, rx_word_d;
  logic [WORD_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  reload_q, reload_d;
  logic                  first_q, first_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  consume;
  logic [WORD_WIDTH-1:0] tx_fill;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                  frame_err_q, frame_err_d;
`endif

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .CLK(CLK), .RST(RST), .din_i(master_clock), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .CLK(CLK), .RST(RST), .din_i(slave_select), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  // MOSI only needs to be synchronised; its edges carry no meaning
  always_ff @(posedge CLK) begin
    if (RST) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
  // An empty buffer transmits zeros
  assign tx_fill     = tx_ready_q ? '0 : tx_buf_q;

  // Frame FSM: bit counting, receive/transmit shifting and buffer consumption
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_word_d  = rx_word_q;
    reload_d   = reload_q;
    first_d    = first_q;
    rx_valid_d = 1'b0;
    consume    = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          cnt_d      = '0;
          tx_shift_d = tx_fill;
          consume    = 1'b1;
          reload_d   = 1'b0;
          first_d    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          // SS wins over a coincident sample edge; partial words are dropped
          state_d  = IDLE;
          cnt_d    = '0;
          reload_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
          frame_err_d = (cnt_q != '0);
`endif
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[WORD_WIDTH-2:0], mosi_sync_q[SYNC_STAGES-1]};
          if (cnt_q == LAST_BIT) begin
            rx_word_d  = {rx_shift_q[WORD_WIDTH-2:0], mosi_sync_q[SYNC_STAGES-1]};
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            reload_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          first_d = 1'b0;
          if (reload_q) begin
            tx_shift_d = tx_fill;
            reload_d   = 1'b0;
            consume    = 1'b1;
          end else if (HOLD_FIRST && first_q) begin
            // CPHA=1: MSB already on MISO since SS fell; keep it for this bit
            tx_shift_d = tx_shift_q;
          end else begin
            tx_shift_d = {tx_shift_q[WORD_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transmit buffer handshake; a load is only honoured while the buffer is empty
  always_comb begin
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    if (tx_load && tx_ready_q) begin
      tx_buf_d   = tx_word;
      tx_ready_d = 1'b0;
    end else if (consume) begin
      tx_ready_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_word_q  <= '0;
      tx_buf_q   <= '0;
      reload_q   <= 1'b0;
      first_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_word_q  <= rx_word_d;
      tx_buf_q   <= tx_buf_d;
      reload_q   <= reload_d;
      first_q    <= first_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign miso     = (state_q == ACTIVE) ? tx_shift_q[WORD_WIDTH-1] : 1'b0;
  assign rx_word  = rx_word_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = tx_ready_q;
  assign busy     = (state_q == ACTIVE);
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_error = frame_err_q;
`endif

endmodule
